// File: rtl/uart_axil_tx_arbiter.sv
// Round-robin arbiter sharing one AXI4-lite UART transmitter between NREQ
// byte producers. Polls TX_BUSY until clear, then writes the granted byte to
// TX_DATA. Optional macro UART_ARB_TIMEOUT_EN aborts a grant after
// TIMEOUT_POLLS busy responses, pulsing REQ_DONE and ERR together.
module uart_axil_tx_arbiter #(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned AXI_AWIDTH    = 4,
  parameter int unsigned AXI_DWIDTH    = 32,
  parameter int unsigned DATA_BITS     = 8,
  parameter logic [AXI_AWIDTH-1:0] ADDR_TX_DATA = AXI_AWIDTH'(0),
  parameter logic [AXI_AWIDTH-1:0] ADDR_TX_BUSY = AXI_AWIDTH'(4),
  parameter int unsigned POLL_GAP      = 16,
  parameter int unsigned TIMEOUT_POLLS = 1024,
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      AXI_ACLK,
  input  logic                      AXI_ARESET,
  input  logic [NREQ-1:0]           REQ_VALID,
  input  logic [NREQ*DATA_BITS-1:0] REQ_DATA,
  output logic [NREQ-1:0]           REQ_DONE,
  output logic [IW-1:0]             GRANT_ID,
  output logic                      BUSY,
  output logic                      ERR,
  output logic [AXI_AWIDTH-1:0]     M_AWADDR,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  output logic [AXI_DWIDTH-1:0]     M_WDATA,
  output logic [AXI_DWIDTH/8-1:0]   M_WSTRB,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  input  logic [1:0]                M_BRESP,
  input  logic                      M_BVALID,
  output logic                      M_BREADY,
  output logic [AXI_AWIDTH-1:0]     M_ARADDR,
  output logic                      M_ARVALID,
  input  logic                      M_ARREADY,
  input  logic [AXI_DWIDTH-1:0]     M_RDATA,
  input  logic [1:0]                M_RRESP,
  input  logic                      M_RVALID,
  output logic                      M_RREADY
);

  localparam int unsigned IW1 = IW + 1;
  localparam int unsigned SW  = AXI_DWIDTH / 8;
  localparam int unsigned GW  = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_GAP, S_W, S_B} state_t;

  state_t                  state, state_n;
  logic [IW-1:0]           ptr, ptr_n, grant_n;
  logic [DATA_BITS-1:0]    byte_q, byte_n;
  logic [GW-1:0]           gap_cnt, gap_n;
  logic                    aw_done, aw_done_n, w_done, w_done_n, b_seen, b_seen_n;
  logic [1:0]              bresp_q, bresp_n;
  logic                    arvalid_n, rready_n, awvalid_n, wvalid_n, bready_n;
  logic [AXI_AWIDTH-1:0]   araddr_n, awaddr_n;
  logic [AXI_DWIDTH-1:0]   wdata_n;
  logic [SW-1:0]           wstrb_n;
  logic [NREQ-1:0]         done_n;
  logic                    err_n, busy_n;
  logic                    aw_hs, w_hs, b_hs, resp_busy;
  logic                    pick_found;
  logic [IW-1:0]           pick_idx;
  logic [IW1-1:0]          pick_sum;
  logic [DATA_BITS-1:0]    pick_byte;
  logic [2*NREQ-1:0]       pick_rot;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned PW = $clog2(TIMEOUT_POLLS + 1);
  logic [PW-1:0]           poll_cnt, poll_n;
`endif

  // Only RDATA bit 0 carries busy status.
  logic unused_rdata;
  assign unused_rdata = ^M_RDATA[AXI_DWIDTH-1:1];

  // Round-robin pick: first requester at or above the pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_sum   = '0;
    pick_byte  = '0;
    pick_rot   = {REQ_VALID, REQ_VALID} >> ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!pick_found && pick_rot[k]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, ptr} + IW1'(k);
      end
    end
    if (pick_sum >= IW1'(NREQ)) pick_sum = pick_sum - IW1'(NREQ);
    pick_idx = pick_sum[IW-1:0];
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) pick_byte = REQ_DATA[i*DATA_BITS +: DATA_BITS];
    end
  end

  // Next-state and next-output computation for every registered signal.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    grant_n   = GRANT_ID;
    byte_n    = byte_q;
    gap_n     = gap_cnt;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    b_seen_n  = b_seen;
    bresp_n   = bresp_q;
    arvalid_n = M_ARVALID;
    rready_n  = M_RREADY;
    awvalid_n = M_AWVALID;
    wvalid_n  = M_WVALID;
    bready_n  = M_BREADY;
    araddr_n  = M_ARADDR;
    awaddr_n  = M_AWADDR;
    wdata_n   = M_WDATA;
    wstrb_n   = M_WSTRB;
    done_n    = '0;
    err_n     = 1'b0;
    aw_hs     = M_AWVALID & M_AWREADY;
    w_hs      = M_WVALID & M_WREADY;
    b_hs      = M_BVALID & M_BREADY;
    resp_busy = M_RDATA[0] | (M_RRESP != 2'b00);
`ifdef UART_ARB_TIMEOUT_EN
    poll_n    = poll_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          grant_n   = pick_idx;
          byte_n    = pick_byte;
          ptr_n     = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
          state_n   = S_AR;
          arvalid_n = 1'b1;
          rready_n  = 1'b1;
          araddr_n  = ADDR_TX_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          poll_n    = '0;
`endif
        end
      end
      S_AR: begin
        if (M_ARVALID && M_ARREADY) begin
          arvalid_n = 1'b0;
          state_n   = S_R;
        end
      end
      S_R: begin
        if (M_RVALID && M_RREADY) begin
          rready_n = 1'b0;
          if (resp_busy) begin
`ifdef UART_ARB_TIMEOUT_EN
            if (poll_cnt == PW'(TIMEOUT_POLLS - 1)) begin
              done_n  = NREQ'(1) << GRANT_ID;
              err_n   = 1'b1;
              state_n = S_IDLE;
            end else begin
              poll_n  = poll_cnt + PW'(1);
              gap_n   = '0;
              state_n = S_GAP;
            end
`else
            gap_n   = '0;
            state_n = S_GAP;
`endif
          end else begin
            state_n   = S_W;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            bready_n  = 1'b1;
            awaddr_n  = ADDR_TX_DATA;
            wdata_n   = AXI_DWIDTH'(byte_q);
            wstrb_n   = '1;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            b_seen_n  = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(POLL_GAP - 1)) begin
          gap_n     = '0;
          state_n   = S_AR;
          arvalid_n = 1'b1;
          rready_n  = 1'b1;
        end else begin
          gap_n = gap_cnt + GW'(1);
        end
      end
      S_W: begin
        if (aw_hs) awvalid_n = 1'b0;
        if (w_hs)  wvalid_n  = 1'b0;
        if (b_hs) begin
          bready_n = 1'b0;
          b_seen_n = 1'b1;
          bresp_n  = M_BRESP;
        end
        aw_done_n = aw_done | aw_hs;
        w_done_n  = w_done | w_hs;
        if (aw_done_n && w_done_n) begin
          if (b_seen || b_hs) begin
            done_n  = NREQ'(1) << GRANT_ID;
            err_n   = (b_hs ? M_BRESP : bresp_q) != 2'b00;
            state_n = S_IDLE;
          end else begin
            state_n = S_B;
          end
        end
      end
      S_B: begin
        if (b_hs) begin
          bready_n = 1'b0;
          done_n   = NREQ'(1) << GRANT_ID;
          err_n    = M_BRESP != 2'b00;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state     <= S_IDLE;
      ptr       <= '0;
      GRANT_ID  <= '0;
      byte_q    <= '0;
      gap_cnt   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      b_seen    <= 1'b0;
      bresp_q   <= '0;
      M_ARVALID <= 1'b0;
      M_RREADY  <= 1'b0;
      M_AWVALID <= 1'b0;
      M_WVALID  <= 1'b0;
      M_BREADY  <= 1'b0;
      M_ARADDR  <= '0;
      M_AWADDR  <= '0;
      M_WDATA   <= '0;
      M_WSTRB   <= '0;
      REQ_DONE  <= '0;
      ERR       <= 1'b0;
      BUSY      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      poll_cnt  <= '0;
`endif
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      GRANT_ID  <= grant_n;
      byte_q    <= byte_n;
      gap_cnt   <= gap_n;
      aw_done   <= aw_done_n;
      w_done    <= w_done_n;
      b_seen    <= b_seen_n;
      bresp_q   <= bresp_n;
      M_ARVALID <= arvalid_n;
      M_RREADY  <= rready_n;
      M_AWVALID <= awvalid_n;
      M_WVALID  <= wvalid_n;
      M_BREADY  <= bready_n;
      M_ARADDR  <= araddr_n;
      M_AWADDR  <= awaddr_n;
      M_WDATA   <= wdata_n;
      M_WSTRB   <= wstrb_n;
      REQ_DONE  <= done_n;
      ERR       <= err_n;
      BUSY      <= busy_n;
`ifdef UART_ARB_TIMEOUT_EN
      poll_cnt  <= poll_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_axil_tx_arbiter.sv
// Scoreboard bench for uart_axil_tx_arbiter: requester models, an AXI4-lite
// UART slave model with configurable stalls/busy/BRESP, and monitors that
// pop expected writes and completions as the DUT presents them.
module tb_uart_axil_tx_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0] req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0] req_done;
  logic [1:0] grant_id;
  logic busy, err;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;

  uart_axil_tx_arbiter #(.NREQ(NREQ), .POLL_GAP(16), .TIMEOUT_POLLS(8)) dut (
    .AXI_ACLK(clk), .AXI_ARESET(rst), .REQ_VALID(req_valid), .REQ_DATA(req_data),
    .REQ_DONE(req_done), .GRANT_ID(grant_id), .BUSY(busy), .ERR(err),
    .M_AWADDR(awaddr), .M_AWVALID(awvalid), .M_AWREADY(awready),
    .M_WDATA(wdata), .M_WSTRB(wstrb), .M_WVALID(wvalid), .M_WREADY(wready),
    .M_BRESP(bresp), .M_BVALID(bvalid), .M_BREADY(bready),
    .M_ARADDR(araddr), .M_ARVALID(arvalid), .M_ARREADY(arready),
    .M_RDATA(rdata), .M_RRESP(rresp), .M_RVALID(rvalid), .M_RREADY(rready));

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard queues
  int         exp_id[$];
  logic       exp_err[$];
  logic [7:0] exp_wr[$];

  // requester models: quota[i] bytes left; byte advances on each REQ_DONE
  int         quota[NREQ];
  logic [7:0] rbyte[NREQ];
  int         rise_cyc[NREQ];
  initial begin
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin quota[i] = 0; rbyte[i] = 8'h00; rise_cyc[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (req_done[i] && quota[i] > 0) begin quota[i]--; rbyte[i]++; end
        if (!req_valid[i] && quota[i] > 0) rise_cyc[i] = cyc;
        req_valid[i] = (quota[i] > 0);
        req_data[i*8 +: 8] = rbyte[i];
      end
    end
  end

  // AXI4-lite slave model
  int busy_left = 0, aw_delay = 0, w_delay = 0;
  logic [1:0] bresp_cfg = 2'b00;
  int ar_cnt = 0, wr_cnt = 0, b_cnt = 0;
  int aw_wait = 0, w_wait = 0, aw_hi = 0, w_hi = 0, aw_hi_rec = 0, w_hi_rec = 0;
  int ar_low = 0, min_gap = 1000;
  bit ar_seen = 0;
  bit ar_f = 0, r_f = 0, aw_f = 0, w_f = 0, b_f = 0, aw_got = 0, w_got = 0;
  logic [AW-1:0] cap_araddr, cap_awaddr, last_araddr;
  logic [DW-1:0] cap_wdata;
  logic [3:0] cap_wstrb;
  initial begin
    logic [7:0] eb;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rdata = '0; rresp = 2'b00; bresp = 2'b00;
    cap_araddr = '0; cap_awaddr = '0; last_araddr = '0; cap_wdata = '0; cap_wstrb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0; aw_got = 0; w_got = 0;
        aw_wait = 0; w_wait = 0; aw_hi = 0; w_hi = 0;
      end else begin
        if (b_f) begin bvalid = 0; b_cnt++; end
        if (r_f) rvalid = 0;
        if (ar_f) begin
          ar_cnt++;
          last_araddr = cap_araddr;
          rvalid = 1; rresp = 2'b00;
          if (busy_left > 0) begin rdata = 32'h1; busy_left--; end
          else rdata = 32'h0;
        end
        if (aw_f) begin aw_got = 1; aw_hi_rec = aw_hi; aw_hi = 0; end
        if (w_f)  begin w_got = 1;  w_hi_rec = w_hi;   w_hi = 0;  end
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0; wr_cnt++;
          bvalid = 1; bresp = bresp_cfg;
          if (exp_wr.size() == 0) check("unexpected_write", {32'h0, cap_wdata}, 64'hdead);
          else begin
            eb = exp_wr.pop_front();
            check("wr_addr", {60'h0, cap_awaddr}, 64'h0);
            check("wr_data", {32'h0, cap_wdata}, {56'h0, eb});
            check("wr_strb", {60'h0, cap_wstrb}, 64'hF);
          end
        end
        if (arvalid) begin
          if (ar_seen && ar_low > 0 && ar_low < min_gap) min_gap = ar_low;
          ar_seen = 1; ar_low = 0;
        end else ar_low++;
        if (awvalid) aw_hi++;
        if (wvalid) w_hi++;
        arready = 1;
        awready = awvalid && (aw_wait >= aw_delay);
        aw_wait = awvalid ? aw_wait + 1 : 0;
        wready  = wvalid && (w_wait >= w_delay);
        w_wait  = wvalid ? w_wait + 1 : 0;
        ar_f = arvalid && arready;  if (ar_f) cap_araddr = araddr;
        r_f  = rvalid && rready;
        aw_f = awvalid && awready;  if (aw_f) cap_awaddr = awaddr;
        w_f  = wvalid && wready;    if (w_f) begin cap_wdata = wdata; cap_wstrb = wstrb; end
        b_f  = bvalid && bready;
      end
    end
  end

  // completion monitor
  int err_cnt = 0, last_done_cyc = 0;
  initial begin
    int   id;
    logic e;
    forever begin
      @(negedge clk);
      if (err) err_cnt++;
      if (req_done != '0) begin
        last_done_cyc = cyc;
        if (exp_id.size() == 0) check("unexpected_done", {60'h0, req_done}, 64'h0);
        else begin
          id = exp_id.pop_front();
          e  = exp_err.pop_front();
          check("done_onehot", {60'h0, req_done}, 64'(1) << id);
          check("grant_id", {62'h0, grant_id}, 64'(id));
          check("done_err", {63'h0, err}, {63'h0, e});
        end
      end
    end
  end

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += quota[i];
    return s;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while ((exp_id.size() != 0 || pending() != 0 || busy) && n < budget);
    check({"wait_", name}, {63'h0, (n >= budget)}, 64'h0);
  endtask

  task automatic push(input int id, input logic [7:0] b, input logic e, input bit wr);
    exp_id.push_back(id);
    exp_err.push_back(e);
    if (wr) exp_wr.push_back(b);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); rst = 1;
    repeat (n) @(negedge clk);
    rst = 0;
  endtask

  int a0, w0, b0, n;
  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_grant", {62'h0, grant_id}, 64'h0);
    check("rst_done_err", {59'h0, req_done, err}, 64'h0);
    check("rst_valids", {59'h0, arvalid, rready, awvalid, wvalid, bready}, 64'h0);
    check("rst_addr_data", {24'h0, araddr, awaddr, wdata}, 64'h0);
    check("rst_wstrb", {60'h0, wstrb}, 64'h0);
    rst = 0;

    // single requester 2, byte A5, slave idle
    @(negedge clk);
    a0 = ar_cnt; w0 = wr_cnt;
    push(2, 8'hA5, 1'b0, 1);
    rbyte[2] = 8'hA5; quota[2] = 1;
    wait_idle("single", 200);
    check("single_latency", 64'(last_done_cyc - rise_cyc[2]), 64'd5);
    check("single_ar_cnt", 64'(ar_cnt - a0), 64'd1);
    check("single_araddr", {60'h0, last_araddr}, 64'h4);
    check("single_wr_cnt", 64'(wr_cnt - w0), 64'd1);

    // all four requesting from reset: order 0,1,2,3,0,1
    do_reset(2);
    push(0, 8'h10, 0, 1); push(1, 8'h20, 0, 1); push(2, 8'h30, 0, 1);
    push(3, 8'h40, 0, 1); push(0, 8'h11, 0, 1); push(1, 8'h21, 0, 1);
    for (int i = 0; i < NREQ; i++) rbyte[i] = 8'(16 * (i + 1));
    quota[0] = 2; quota[1] = 2; quota[2] = 1; quota[3] = 1;
    wait_idle("rr", 400);

    // busy for three polls then free
    @(negedge clk);
    a0 = ar_cnt; w0 = wr_cnt; busy_left = 3; ar_seen = 0; min_gap = 1000;
    push(1, 8'h5A, 0, 1);
    rbyte[1] = 8'h5A; quota[1] = 1;
    wait_idle("poll", 400);
    check("poll_ar_cnt", 64'(ar_cnt - a0), 64'd4);
    check("poll_gap_ok", {63'h0, (min_gap >= 16 && min_gap < 1000)}, 64'h1);
    check("poll_wr_cnt", 64'(wr_cnt - w0), 64'd1);

    // AWREADY delayed 3 cycles, WREADY immediate
    @(negedge clk);
    b0 = b_cnt; aw_delay = 3; w_delay = 0;
    push(3, 8'h3C, 0, 1);
    rbyte[3] = 8'h3C; quota[3] = 1;
    wait_idle("awdly", 200);
    check("awvalid_cycles", 64'(aw_hi_rec), 64'd4);
    check("wvalid_cycles", 64'(w_hi_rec), 64'd1);
    check("awdly_b_cnt", 64'(b_cnt - b0), 64'd1);
    aw_delay = 0;

    // SLVERR on the write, then a normal transaction
    @(negedge clk);
    err_cnt = 0; bresp_cfg = 2'b10;
    push(0, 8'h77, 1, 1);
    rbyte[0] = 8'h77; quota[0] = 1;
    wait_idle("slverr", 200);
    bresp_cfg = 2'b00;
    push(1, 8'h88, 0, 1);
    rbyte[1] = 8'h88; quota[1] = 1;
    wait_idle("after_err", 200);
    check("slverr_err_pulses", 64'(err_cnt), 64'd1);

`ifdef UART_ARB_TIMEOUT_EN
    // busy stuck: eight polls then abort with ERR
    @(negedge clk);
    a0 = ar_cnt; w0 = wr_cnt; err_cnt = 0; busy_left = 1000;
    push(2, 8'hE1, 1, 0);
    rbyte[2] = 8'hE1; quota[2] = 1;
    wait_idle("timeout", 600);
    busy_left = 0;
    check("timeout_ar_cnt", 64'(ar_cnt - a0), 64'd8);
    check("timeout_wr_cnt", 64'(wr_cnt - w0), 64'd0);
    check("timeout_err_pulses", 64'(err_cnt), 64'd1);
`endif

    // reset while in W: everything drops, pointer returns to 0
    @(negedge clk);
    aw_delay = 20;
    rbyte[0] = 8'h99; quota[0] = 1;
    n = 0;
    while (!awvalid && n < 100) begin @(negedge clk); n++; end
    check("reach_w_state", {63'h0, awvalid}, 64'h1);
    rst = 1;
    rbyte[1] = 8'hAB; quota[1] = 1;
    @(negedge clk); #1;
    check("rstw_valids", {59'h0, arvalid, rready, awvalid, wvalid, bready}, 64'h0);
    check("rstw_busy", {63'h0, busy}, 64'h0);
    check("rstw_no_done", {60'h0, req_done}, 64'h0);
    @(negedge clk);
    exp_id.delete(); exp_err.delete(); exp_wr.delete();
    aw_delay = 0;
    push(0, 8'h99, 0, 1);
    push(1, 8'hAB, 0, 1);
    rst = 0;
    wait_idle("after_rst", 300);

    check("queues_empty", 64'(exp_id.size() + exp_wr.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
